// File: rtl/afbc_pkg.sv
// Shared types and constants for the AFBC tile scheduler.
// Tag fields use the widest supported sizes; the scheduler narrows them on use.
package afbc_pkg;

  localparam int AFBC_CMP_BYTES = 128;
  localparam int AFBC_SRC_W     = 3;   // up to 8 requesters
  localparam int AFBC_TILE_W    = 32;  // widest supported tile ID

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [AFBC_SRC_W-1:0]  src;
    logic [AFBC_TILE_W-1:0] tile_id;
  } afbc_tag_t;

endpackage

// File: rtl/afbc_tag_fifo.sv
// In-order FIFO of block tags awaiting their compressed output.
// Push is ignored when full and pop when empty.
module afbc_tag_fifo
  import afbc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  afbc_tag_t              i_data,
  input  logic                   i_pop,
  output afbc_tag_t              o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  afbc_tag_t        r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/afbc_tile_scheduler.sv
// Round-robin arbiter sharing one AFBC compressor between N_REQ tile producers,
// re-tagging each compressed block with its source requester and tile ID.
module afbc_tile_scheduler
  import afbc_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PIX_W     = 4096,
  parameter int unsigned CMP_W     = AFBC_CMP_BYTES * 8,
  parameter int unsigned TILE_W    = 16,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*TILE_W-1:0]      req_tile_id,
  input  logic [N_REQ*PIX_W-1:0]       req_pixels,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0]             req_enable,
  output logic                         blk_valid,
  output logic [PIX_W-1:0]             blk_pixels,
  input  logic                         blk_ready,
  input  logic                         cmp_valid,
  input  logic [CMP_W-1:0]             cmp_data,
  output logic                         cmp_ready,
  output logic                         out_valid,
  output logic [CMP_W-1:0]             out_data,
  output logic [$clog2(N_REQ)-1:0]     out_src,
  output logic [TILE_W-1:0]            out_tile_id,
  input  logic                         out_ready,
  input  logic                         drain_req,
  output logic                         drain_done,
  output logic [$clog2(TAG_DEPTH):0]   inflight,
  output logic                         err_orphan
);

  localparam int unsigned SRC_W = $clog2(N_REQ);

  sched_state_t       r_state;
  sched_state_t       w_state_nxt;
  logic [SRC_W-1:0]   r_ptr;
  logic [N_REQ-1:0]   w_elig;
  logic               w_any;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W-1:0]   w_idx;
  logic               w_issue_ok;
  logic               w_hs;
  afbc_tag_t          w_push_tag;
  afbc_tag_t          w_head;
  logic               w_full;
  logic               w_empty;

  logic               r_out_valid;
  logic [CMP_W-1:0]   r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic [TILE_W-1:0]  r_out_tile;
  logic               r_err;

  assign w_elig     = req_valid & req_enable;
  assign w_issue_ok = (r_state == RUN) & ~w_full;
  assign blk_valid  = w_issue_ok & w_any;
  assign blk_pixels = req_pixels[w_win*PIX_W +: PIX_W];
  assign w_hs       = blk_valid & blk_ready;

  // First eligible requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = SRC_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_any && w_elig[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    req_ready        = '0;
    req_ready[w_win] = w_issue_ok & blk_ready & w_any;
  end

  always_comb begin
    w_push_tag.src     = AFBC_SRC_W'(w_win);
    w_push_tag.tile_id = AFBC_TILE_W'(req_tile_id[w_win*TILE_W +: TILE_W]);
  end

  afbc_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_hs),
    .i_data  (w_push_tag),
    .i_pop   (cmp_valid),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (inflight)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:     if (drain_req) w_state_nxt = DRAIN;
      DRAIN:   if (w_empty && !r_out_valid) w_state_nxt = DONE;
      DONE:    if (!drain_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) r_ptr <= (w_win == SRC_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

  // The compressor only pulses after seeing cmp_ready, so a load never hits a full register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_out_tile  <= '0;
      r_err       <= 1'b0;
    end else if (cmp_valid) begin
      r_out_valid <= 1'b1;
      r_out_data  <= cmp_data;
      if (w_empty) begin
        r_out_src  <= '0;
        r_out_tile <= '0;
        r_err      <= 1'b1;
      end else begin
        r_out_src  <= SRC_W'(w_head.src);
        r_out_tile <= TILE_W'(w_head.tile_id);
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign cmp_ready   = ~r_out_valid;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_src     = r_out_src;
  assign out_tile_id = r_out_tile;
  assign err_orphan  = r_err;
  assign drain_done  = (r_state == DONE);

endmodule

// File: tb/tb_afbc_tile_scheduler.sv
// Scoreboard bench for afbc_tile_scheduler with a behavioural compressor and requesters.
module tb_afbc_tile_scheduler;

  localparam int N  = 4;
  localparam int PW = 4096;
  localparam int CW = 1024;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, req_enable;
  logic [N*TW-1:0] req_tile_id;
  logic [N*PW-1:0] req_pixels;
  logic            blk_valid, blk_ready;
  logic [PW-1:0]   blk_pixels;
  logic            cmp_valid = 1'b0;
  logic            cmp_ready;
  logic [CW-1:0]   cmp_data = '0;
  logic            out_valid, out_ready;
  logic [CW-1:0]   out_data;
  logic [1:0]      out_src;
  logic [TW-1:0]   out_tile_id;
  logic            drain_req, drain_done, err_orphan;
  logic [2:0]      inflight;

  afbc_tile_scheduler #(
    .N_REQ(N), .PIX_W(PW), .CMP_W(CW), .TILE_W(TW), .TAG_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_tile_id(req_tile_id), .req_pixels(req_pixels),
    .req_ready(req_ready), .req_enable(req_enable),
    .blk_valid(blk_valid), .blk_pixels(blk_pixels), .blk_ready(blk_ready),
    .cmp_valid(cmp_valid), .cmp_data(cmp_data), .cmp_ready(cmp_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_tile_id(out_tile_id), .out_ready(out_ready),
    .drain_req(drain_req), .drain_done(drain_done),
    .inflight(inflight), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [1:0]    src;
    logic [TW-1:0] id;
    logic [CW-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  int unsigned n_out    = 0;
  int unsigned cnt02    = 0;
  int unsigned cnt_any  = 0;

  int unsigned   load_cnt[N] = '{default: 0};
  int unsigned   sent[N]     = '{default: 0};
  logic [TW-1:0] id_of[N]    = '{default: '0};

  logic          hold = 1'b0;
  int unsigned   inj_req = 0;
  int unsigned   inj_done = 0;
  logic [CW-1:0] inj_data = '0;

  // Quarter q of requester i's tile number s; the payload is quarter 0.
  function automatic logic [CW-1:0] quarter(input int unsigned i, input int unsigned s,
                                            input int unsigned q);
    logic [31:0] w;
    w = {8'hA5, q[7:0], i[7:0], s[7:0]};
    return {32{w}};
  endfunction

  function automatic logic [PW-1:0] pix(input int unsigned i, input int unsigned s);
    return {quarter(i, s, 3), quarter(i, s, 2), quarter(i, s, 1), quarter(i, s, 0)};
  endfunction

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Requesters: tiles loaded minus tiles sent are still pending.
  always_comb begin
    req_valid   = '0;
    req_tile_id = '0;
    req_pixels  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]             = (load_cnt[i] != sent[i]);
      req_tile_id[i*TW +: TW]  = id_of[i];
      req_pixels[i*PW +: PW]   = pix(i, sent[i]);
    end
  end

  always begin : req_driver
    logic [N-1:0] acc;
    @(posedge clk);
    acc = req_valid & req_ready;
    if (req_ready[0] || req_ready[2]) cnt02++;
    if (|req_ready) cnt_any++;
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) sent[i]++;
  end

  // Compressor: one-cycle minimum latency, pulses only after seeing cmp_ready with no pulse pending.
  logic [CW-1:0] cq[$];
  always begin : comp_model
    logic          s_rdy, s_vld, s_acc, emit;
    logic [CW-1:0] s_pix, d;
    @(posedge clk);
    s_rdy = cmp_ready;
    s_vld = cmp_valid;
    s_acc = blk_valid & blk_ready;
    s_pix = blk_pixels[CW-1:0];
    emit  = 1'b0;
    d     = cmp_data;
    if (!rst_n) begin
      cq.delete();
      inj_done = inj_req;
    end else begin
      if (s_rdy && !s_vld) begin
        if (inj_req != inj_done) begin
          emit = 1'b1;
          d    = inj_data;
          inj_done++;
        end else if (!hold && cq.size() != 0) begin
          emit = 1'b1;
          d    = cq.pop_front();
        end
      end
      if (s_acc) cq.push_back(s_pix);
    end
    #1;
    cmp_valid = emit;
    cmp_data  = d;
  end

  exp_t        mon_e;
  logic [31:0] mon_gw, mon_ew;
  logic        mon_found;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("out_unexpected", 1'b0, 64'(out_tile_id), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        n_out++;
        check("out_src", out_src == mon_e.src, 64'(out_src), 64'(mon_e.src));
        check("out_tile_id", out_tile_id == mon_e.id, 64'(out_tile_id), 64'(mon_e.id));
        mon_gw = out_data[31:0];
        mon_ew = mon_e.data[31:0];
        mon_found = 1'b0;
        for (int k = 0; k < CW / 32; k++) begin
          if (!mon_found && out_data[k*32 +: 32] != mon_e.data[k*32 +: 32]) begin
            mon_found = 1'b1;
            mon_gw    = out_data[k*32 +: 32];
            mon_ew    = mon_e.data[k*32 +: 32];
          end
        end
        check("out_data", out_data == mon_e.data, 64'(mon_gw), 64'(mon_ew));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned i, input int unsigned n);
    load_cnt[i] = load_cnt[i] + n;
  endtask

  task automatic expect_tile(input int unsigned i, input int unsigned s);
    exp_t e;
    e.src  = 2'(i);
    e.id   = id_of[i];
    e.data = quarter(i, s, 0);
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((sb.size() != 0 || inflight != 0 || out_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, sb.size() == 0 && inflight == 0 && !out_valid, 64'(sb.size()), 64'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
    check("rst_drain_done", drain_done == 1'b0, 64'(drain_done), 64'd0);
    check("rst_err_orphan", err_orphan == 1'b0, 64'(err_orphan), 64'd0);
    check("rst_inflight", inflight == 3'd0, 64'(inflight), 64'd0);
    check("rst_blk_valid", blk_valid == 1'b0, 64'(blk_valid), 64'd0);
    check("rst_cmp_ready", cmp_ready == 1'b1, 64'(cmp_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t;
    int unsigned snap;
    exp_t e;
    req_enable = '1;
    out_ready  = 1'b1;
    drain_req  = 1'b0;
    blk_ready  = 1'b1;
    apply_reset();

    // Single tile from requester 0.
    id_of[0] = 16'h0012;
    expect_tile(0, load_cnt[0]);
    load(0, 1);
    wait_idle("t1_idle");
    check("t1_inflight", inflight == 3'd0, 64'(inflight), 64'd0);

    // Fresh pointer: all four requesters rotate 0,1,2,3,0,1,2,3.
    apply_reset();
    for (int i = 0; i < N; i++) id_of[i] = 16'h00A0 + 16'(i);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) expect_tile(i, load_cnt[i] + k);
    for (int i = 0; i < N; i++) load(i, 2);
    wait_idle("t2_idle");

    // Masked requesters 0 and 2: grants alternate 1,3,1,3.
    req_enable = 4'b1010;
    snap = cnt02;
    for (int k = 0; k < 2; k++) begin
      expect_tile(1, load_cnt[1] + k);
      expect_tile(3, load_cnt[3] + k);
    end
    for (int i = 0; i < N; i++) load(i, 2);
    wait_idle("t3_idle");
    check("t3_ready02", cnt02 == snap, 64'(cnt02 - snap), 64'd0);
    load_cnt[0] = sent[0];
    load_cnt[2] = sent[2];
    req_enable  = '1;
    tick();

    // Downstream stall with six tiles queued; pointer is 0 after last winner 3.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_tile(0, load_cnt[0] + k);
      expect_tile(1, load_cnt[1] + k);
    end
    load(0, 3);
    load(1, 3);
    repeat (50) @(negedge clk);
    check("t4_inflight_full", inflight == 3'd4, 64'(inflight), 64'd4);
    check("t4_blk_valid", blk_valid == 1'b0, 64'(blk_valid), 64'd0);
    check("t4_cmp_ready", cmp_ready == 1'b0, 64'(cmp_ready), 64'd0);
    check("t4_out_held", out_valid == 1'b1, 64'(out_valid), 64'd1);
    check("t4_pending", sb.size() == 6, 64'(sb.size()), 64'd6);
    tick();
    out_ready = 1'b1;
    wait_idle("t4_idle");

    // Drain with three blocks held in the compressor; pointer is 2 after last winner 1.
    hold = 1'b1;
    for (int k = 0; k < 3; k++) expect_tile(1, load_cnt[1] + k);
    load(1, 3);
    t = 0;
    while (inflight != 3'd3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t5_inflight3", inflight == 3'd3, 64'(inflight), 64'd3);
    check("t5_done_early", drain_done == 1'b0, 64'(drain_done), 64'd0);
    tick();
    drain_req = 1'b1;
    tick();
    snap = cnt_any;
    expect_tile(2, load_cnt[2]);
    expect_tile(0, load_cnt[0]);
    load(2, 1);
    load(0, 1);
    repeat (10) @(negedge clk);
    check("t5_no_ready", cnt_any == snap, 64'(cnt_any - snap), 64'd0);
    check("t5_blk_valid", blk_valid == 1'b0, 64'(blk_valid), 64'd0);
    snap = n_out;
    tick();
    hold = 1'b0;
    t = 0;
    while (!drain_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("t5_drain_done", drain_done == 1'b1, 64'(drain_done), 64'd1);
    check("t5_drained_outs", n_out - snap == 3, 64'(n_out - snap), 64'd3);
    check("t5_inflight0", inflight == 3'd0, 64'(inflight), 64'd0);
    tick();
    drain_req = 1'b0;
    wait_idle("t5_resume_idle");
    check("t5_done_clear", drain_done == 1'b0, 64'(drain_done), 64'd0);

    // Orphan compressed block, then normal traffic keeps the flag set.
    inj_data = {32{32'h0BAD_F00D}};
    e.src  = 2'd0;
    e.id   = '0;
    e.data = inj_data;
    sb.push_back(e);
    inj_req++;
    wait_idle("t6_orphan_idle");
    check("t6_err_set", err_orphan == 1'b1, 64'(err_orphan), 64'd1);
    expect_tile(3, load_cnt[3]);
    load(3, 1);
    wait_idle("t6_traffic_idle");
    check("t6_err_sticky", err_orphan == 1'b1, 64'(err_orphan), 64'd1);
    apply_reset();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
